mem_block_pipe: RTL

- Parametrised successor of the per-block SRAM slice in the vector-cache SRAM group, daisy-chained west↔east with its neighbours.
- Read and write commands pass through combinationally; commands addressed to this block (BLOCK_ID) access a local NUM_CH-channel SRAM.
- Read results merge onto the west→east data ring. Unlike the previous generation, displaced through-data is buffered per channel (no silent overwrite), writes carry byte enables, and same-cycle read/write hazards are bypassed and counted.

---
 rtl/mem_block_pipe_if.sv | 61 ++++++
 rtl/mem_block_pipe.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_block_pipe_if.sv
// Channelised command/data bus of one vector-cache SRAM block: west->east reads and data ring,
// east->west writes. The block sits on the slave side; its neighbours (or a bench) on the master side.
interface mem_block_pipe_if #(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int BLK_W  = 3,
    parameter int TAG_W  = 8
);
    localparam int BE_W = DATA_W / 8;

    logic [NUM_CH-1:0]             west_rd_vld_in;
    logic [NUM_CH-1:0][ADDR_W-1:0] west_rd_addr_in;
    logic [NUM_CH-1:0][BLK_W-1:0]  west_rd_blk_in;
    logic [NUM_CH-1:0][TAG_W-1:0]  west_rd_tag_in;
    logic [NUM_CH-1:0]             east_rd_vld_out;
    logic [NUM_CH-1:0][ADDR_W-1:0] east_rd_addr_out;
    logic [NUM_CH-1:0][BLK_W-1:0]  east_rd_blk_out;
    logic [NUM_CH-1:0][TAG_W-1:0]  east_rd_tag_out;

    logic [NUM_CH-1:0]             east_wr_vld_in;
    logic [NUM_CH-1:0][ADDR_W-1:0] east_wr_addr_in;
    logic [NUM_CH-1:0][BLK_W-1:0]  east_wr_blk_in;
    logic [NUM_CH-1:0][BE_W-1:0]   east_wr_be_in;
    logic [NUM_CH-1:0][DATA_W-1:0] east_wr_data_in;
    logic [NUM_CH-1:0]             west_wr_vld_out;
    logic [NUM_CH-1:0][ADDR_W-1:0] west_wr_addr_out;
    logic [NUM_CH-1:0][BLK_W-1:0]  west_wr_blk_out;
    logic [NUM_CH-1:0][BE_W-1:0]   west_wr_be_out;
    logic [NUM_CH-1:0][DATA_W-1:0] west_wr_data_out;

    logic [NUM_CH-1:0]             west_data_vld_in;
    logic [NUM_CH-1:0][DATA_W-1:0] west_data_in;
    logic [NUM_CH-1:0][TAG_W-1:0]  west_data_tag_in;
    logic [NUM_CH-1:0]             west_data_rdy_out;
    logic [NUM_CH-1:0]             east_data_vld_out;
    logic [NUM_CH-1:0][DATA_W-1:0] east_data_out;
    logic [NUM_CH-1:0][TAG_W-1:0]  east_data_tag_out;

    logic [15:0]                   raw_conflict_cnt;

    modport slave (
        input  west_rd_vld_in, west_rd_addr_in, west_rd_blk_in, west_rd_tag_in,
        output east_rd_vld_out, east_rd_addr_out, east_rd_blk_out, east_rd_tag_out,
        input  east_wr_vld_in, east_wr_addr_in, east_wr_blk_in, east_wr_be_in, east_wr_data_in,
        output west_wr_vld_out, west_wr_addr_out, west_wr_blk_out, west_wr_be_out, west_wr_data_out,
        input  west_data_vld_in, west_data_in, west_data_tag_in,
        output west_data_rdy_out, east_data_vld_out, east_data_out, east_data_tag_out,
        output raw_conflict_cnt
    );

    modport master (
        output west_rd_vld_in, west_rd_addr_in, west_rd_blk_in, west_rd_tag_in,
        input  east_rd_vld_out, east_rd_addr_out, east_rd_blk_out, east_rd_tag_out,
        output east_wr_vld_in, east_wr_addr_in, east_wr_blk_in, east_wr_be_in, east_wr_data_in,
        input  west_wr_vld_out, west_wr_addr_out, west_wr_blk_out, west_wr_be_out, west_wr_data_out,
        output west_data_vld_in, west_data_in, west_data_tag_in,
        input  west_data_rdy_out, east_data_vld_out, east_data_out, east_data_tag_out,
        input  raw_conflict_cnt
    );
endinterface

// File: rtl/mem_block_pipe.sv
// Per-block SRAM slice of the vector-cache ring: commands pass through, local reads merge onto the
// west->east data ring, displaced through-data is queued per channel so nothing is overwritten.
module mem_block_ch #(
    parameter int BLOCK_ID   = 0,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 8,
    parameter int BLK_W      = 3,
    parameter int TAG_W      = 8,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rd_vld,
    input  logic [ADDR_W-1:0]   rd_addr,
    input  logic [BLK_W-1:0]    rd_blk,
    input  logic [TAG_W-1:0]    rd_tag,
    input  logic                wr_vld,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [BLK_W-1:0]    wr_blk,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                in_vld,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                in_rdy,
    output logic                out_vld,
    output logic [DATA_W-1:0]   out_data,
    output logic [TAG_W-1:0]    out_tag,
    output logic                raw_hit
);
    localparam int BE_W  = DATA_W / 8;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic              rd_hit, wr_hit;
    logic [DATA_W-1:0] rd_word;

    assign rd_hit  = rd_vld && (rd_blk == BLK_W'(BLOCK_ID));
    assign wr_hit  = wr_vld && (wr_blk == BLK_W'(BLOCK_ID));
    assign raw_hit = rd_hit && wr_hit && (rd_addr == wr_addr);

    // Same-cycle write to the read address is forwarded byte-wise into the read data.
    always_comb begin
        rd_word = mem[rd_addr];
        if (raw_hit) begin
            for (int b = 0; b < BE_W; b++)
                if (wr_be[b]) rd_word[b*8 +: 8] = wr_data[b*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_hit) begin
            for (int b = 0; b < BE_W; b++)
                if (wr_be[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
    end

    logic [RD_LAT:1]             vld_pipe;
    logic [RD_LAT:1][DATA_W-1:0] data_pipe;
    logic [RD_LAT:1][TAG_W-1:0]  tag_pipe;

    always_ff @(posedge clk) begin
        if (!rst_n) vld_pipe[1] <= 1'b0;
        else        vld_pipe[1] <= rd_hit;
        data_pipe[1] <= rd_word;
        tag_pipe[1]  <= rd_tag;
        for (int s = 2; s <= RD_LAT; s++) begin
            if (!rst_n) vld_pipe[s] <= 1'b0;
            else        vld_pipe[s] <= vld_pipe[s-1];
            data_pipe[s] <= data_pipe[s-1];
            tag_pipe[s]  <= tag_pipe[s-1];
        end
    end

    logic                                loc_vld;
    logic [FIFO_DEPTH-1:0][DATA_W-1:0] fifo_data;
    logic [FIFO_DEPTH-1:0][TAG_W-1:0]  fifo_tag;
    logic [PTR_W-1:0]                  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]                  count;
    logic                              fifo_empty, take, push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign loc_vld    = vld_pipe[RD_LAT];
    assign fifo_empty = (count == '0);
    assign in_rdy     = (count != CNT_W'(FIFO_DEPTH));
    assign take       = in_vld && in_rdy;
    // Anything already queued must drain before newer beats, so a busy slot or backlog queues the beat.
    assign push       = take && (loc_vld || !fifo_empty);
    assign pop        = !loc_vld && !fifo_empty;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= in_data;
            fifo_tag[wr_ptr]  <= in_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            out_data <= '0;
            out_tag  <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            out_vld <= loc_vld || !fifo_empty || take;
            if (loc_vld) begin
                out_data <= data_pipe[RD_LAT];
                out_tag  <= tag_pipe[RD_LAT];
            end else if (!fifo_empty) begin
                out_data <= fifo_data[rd_ptr];
                out_tag  <= fifo_tag[rd_ptr];
            end else if (take) begin
                out_data <= in_data;
                out_tag  <= in_tag;
            end
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end
endmodule

module mem_block_pipe #(
    parameter int BLOCK_ID   = 0,
    parameter int NUM_CH     = 8,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 8,
    parameter int BLK_W      = 3,
    parameter int TAG_W      = 8,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 2
) (
    input logic             clk,
    input logic             rst_n,
    mem_block_pipe_if.slave bus
);
    localparam int SUM_W = $clog2(NUM_CH + 1);

    assign bus.east_rd_vld_out  = bus.west_rd_vld_in;
    assign bus.east_rd_addr_out = bus.west_rd_addr_in;
    assign bus.east_rd_blk_out  = bus.west_rd_blk_in;
    assign bus.east_rd_tag_out  = bus.west_rd_tag_in;
    assign bus.west_wr_vld_out  = bus.east_wr_vld_in;
    assign bus.west_wr_addr_out = bus.east_wr_addr_in;
    assign bus.west_wr_blk_out  = bus.east_wr_blk_in;
    assign bus.west_wr_be_out   = bus.east_wr_be_in;
    assign bus.west_wr_data_out = bus.east_wr_data_in;

    logic [NUM_CH-1:0]             raw_hit, rdy, out_vld;
    logic [NUM_CH-1:0][DATA_W-1:0] out_data;
    logic [NUM_CH-1:0][TAG_W-1:0]  out_tag;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        mem_block_ch #(
            .BLOCK_ID(BLOCK_ID), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BLK_W(BLK_W),
            .TAG_W(TAG_W), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
        ) u_ch (
            .clk(clk), .rst_n(rst_n),
            .rd_vld(bus.west_rd_vld_in[c]), .rd_addr(bus.west_rd_addr_in[c]),
            .rd_blk(bus.west_rd_blk_in[c]), .rd_tag(bus.west_rd_tag_in[c]),
            .wr_vld(bus.east_wr_vld_in[c]), .wr_addr(bus.east_wr_addr_in[c]),
            .wr_blk(bus.east_wr_blk_in[c]), .wr_be(bus.east_wr_be_in[c]),
            .wr_data(bus.east_wr_data_in[c]),
            .in_vld(bus.west_data_vld_in[c]), .in_data(bus.west_data_in[c]),
            .in_tag(bus.west_data_tag_in[c]), .in_rdy(rdy[c]),
            .out_vld(out_vld[c]), .out_data(out_data[c]), .out_tag(out_tag[c]),
            .raw_hit(raw_hit[c])
        );
    end

    assign bus.west_data_rdy_out = rdy;
    assign bus.east_data_vld_out = out_vld;
    assign bus.east_data_out     = out_data;
    assign bus.east_data_tag_out = out_tag;

    logic [SUM_W-1:0] raw_sum;
    logic [16:0]      cnt_next;
    logic [15:0]      cnt;

    always_comb begin
        raw_sum = '0;
        for (int c = 0; c < NUM_CH; c++) raw_sum = raw_sum + SUM_W'(raw_hit[c]);
    end

    assign cnt_next = {1'b0, cnt} + 17'(raw_sum);

    always_ff @(posedge clk) begin
        if (!rst_n)           cnt <= '0;
        else if (cnt_next[16]) cnt <= 16'hFFFF;
        else                  cnt <= cnt_next[15:0];
    end

    assign bus.raw_conflict_cnt = cnt;
endmodule
